// File: rtl/alu_op_sequencer.sv
// Issues one ALU op at a time: decode at accept, hold alu_op through EXEC (multi-cycle mult/div), then writeback strobe(s).
// Latency: accept -> EXEC for N cycles -> WB (+WB2 for swap); in_ready only in IDLE, so no overlap.
module alu_op_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8,
    parameter int TAG_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_aluop,
    input  logic [3:0]       in_funct,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_divz,
    input  logic             abort,
    output logic [3:0]       alu_op,
    output logic             alu_en,
    output logic             wb_en,
    output logic             wb_sel,
    output logic [TAG_W-1:0] wb_tag,
    output logic             done,
    output logic             err
);

    if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul
        $error("MUL_CYCLES must be in 1..15");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div
        $error("DIV_CYCLES must be in 1..15");
    end

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_MOVE = 4'b0101;
    localparam logic [3:0] OP_SWAP = 4'b0110;
    localparam logic [3:0] OP_LOG  = 4'b0111;
    localparam logic [3:0] OP_01   = 4'b1001;

    typedef enum logic [1:0] {IDLE, EXEC, WB, WB2} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] op_dec;
    logic       divz_q;
    logic       accept;

    assign in_ready = rst_n && (state_q == IDLE) && !abort;
    assign accept   = in_valid && in_ready;

    always_comb begin
        op_dec = OP_NOP;
        case (in_aluop)
            2'b11: begin
                case (in_funct)
                    4'b0000: op_dec = OP_ADD;
                    4'b0010: op_dec = OP_SUB;
                    4'b0100: op_dec = OP_MUL;
                    4'b0101: op_dec = OP_DIV;
                    4'b0111: op_dec = OP_MOVE;
                    4'b1000: op_dec = OP_SWAP;
                    default: op_dec = OP_ADD;
                endcase
            end
            2'b10:   op_dec = OP_LOG;
            2'b01:   op_dec = OP_01;
            default: op_dec = OP_NOP;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (op_dec == OP_MUL)      cnt_d = 4'(MUL_CYCLES - 1);
                        else if (op_dec == OP_DIV) cnt_d = 4'(DIV_CYCLES - 1);
                        else                       cnt_d = 4'd0;
                        // Divide by zero has nothing to compute; go straight to the error writeback.
                        state_d = (op_dec == OP_DIV && in_divz) ? WB : EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                    else               state_d = WB;
                end
                WB:      state_d = (alu_op == OP_SWAP) ? WB2 : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            alu_op  <= OP_NOP;
            wb_tag  <= '0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                alu_op <= op_dec;
                wb_tag <= in_tag;
                divz_q <= (op_dec == OP_DIV) && in_divz;
            end
        end
    end

    // Strobes are decoded from state and suppressed by abort in the same cycle.
    always_comb begin
        alu_en = 1'b0;
        wb_en  = 1'b0;
        wb_sel = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        case (state_q)
            EXEC: alu_en = !abort;
            WB: begin
                wb_en = !abort && (alu_op != OP_NOP) && !divz_q;
                done  = !abort && (alu_op != OP_SWAP);
                err   = !abort && divz_q;
            end
            WB2: begin
                wb_en  = !abort;
                wb_sel = 1'b1;
                done   = !abort;
            end
            default: ;
        endcase
    end

endmodule
